// File: rtl/enc_round_sequencer_pkg.sv
// enc_round_sequencer_pkg: shared state encoding, flags, defaults and stage indices
package enc_round_sequencer_pkg;
    localparam int LEN_STATE = 3;
    typedef enum logic [LEN_STATE-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_STORE = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int NUM_STAGES_DEF = 5;
    localparam int NUM_ROUNDS_DEF = 24;
    localparam int WDT_CYCLES_DEF = 1024;
    localparam int STG_COLPAR  = 0;
    localparam int STG_ROTATE  = 1;
    localparam int STG_PERMUTE = 2;
    localparam int STG_REVAL   = 3;
    localparam int STG_ADDRC   = 4;
endpackage

// File: rtl/enc_step_counter.sv
// enc_step_counter: nested stage/round counters; clr_i zeroes both, adv_i steps one stage
// Ports: clk, rst (async high), clr_i, adv_i, stage_o, round_o, last_stage_o, last_round_o
module enc_step_counter
    import enc_round_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [SW-1:0] stage_o,
    output logic [RW-1:0] round_o,
    output logic          last_stage_o,
    output logic          last_round_o
);
    logic [SW-1:0] stage_q, stage_d;
    logic [RW-1:0] round_q, round_d;
    logic          last_step;
    assign last_stage_o = stage_q == SW'(NUM_STAGES - 1);
    assign last_round_o = round_q == RW'(NUM_ROUNDS - 1);
    assign last_step    = last_stage_o && last_round_o;
    // round holds at its last value after the final stage so it never wraps mid-run
    always_comb begin
        stage_d = clr_i ? '0 : !adv_i ? stage_q : last_stage_o ? '0 : stage_q + 1'b1;
        round_d = clr_i ? '0 : (adv_i && last_stage_o && !last_step) ? round_q + 1'b1 : round_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            round_q <= '0;
        end else begin
            stage_q <= stage_d;
            round_q <= round_d;
        end
    end
    assign stage_o = stage_q;
    assign round_o = round_q;
endmodule

// File: rtl/enc_round_sequencer.sv
// enc_round_sequencer: schedules load, NUM_ROUNDS x NUM_STAGES stage runs, then store
// Ports: clk, rst (async high), start_i, load_done_i, store_done_i, stage_done_i[NUM_STAGES];
//        stage_start_o (one-hot pulse), stage_sel_o, round_o, load_o, store_o, busy_o, done_o, error_o
// Macro ENC_WDT_EN adds a WAIT watchdog (WDT_CYCLES) and the ERR state.
module enc_round_sequencer
    import enc_round_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
`ifdef ENC_WDT_EN
    parameter int WDT_CYCLES = WDT_CYCLES_DEF,
`endif
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  load_done_i,
    input  logic                  store_done_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_start_o,
    output logic [SW-1:0]         stage_sel_o,
    output logic [RW-1:0]         round_o,
    output logic                  load_o,
    output logic                  store_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    state_e state_q, state_d;
    logic   last_stage, last_round, cnt_clr, sel_done, wdt_trip;
    enc_step_counter #(.NUM_STAGES(NUM_STAGES), .NUM_ROUNDS(NUM_ROUNDS)) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cnt_clr),
        .adv_i        (state_q == S_NEXT),
        .stage_o      (stage_sel_o),
        .round_o      (round_o),
        .last_stage_o (last_stage),
        .last_round_o (last_round)
    );
    assign sel_done = stage_done_i[stage_sel_o];
    // counters read zero in IDLE and ERR, so a run out of either starts at round 0, stage 0
    assign cnt_clr = (state_d == S_IDLE) || (state_d == S_ERR);
`ifdef ENC_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES) + 1;
    logic [WW-1:0] wdt_q, wdt_d;
    // trips on the WAIT cycle whose increment would reach WDT_CYCLES-1
    assign wdt_d    = (state_q == S_ISSUE) ? '0 : (state_q == S_WAIT) ? wdt_q + 1'b1 : wdt_q;
    assign wdt_trip = (wdt_q + 1'b1) == WW'(WDT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdt_q <= '0;
        else     wdt_q <= wdt_d;
    end
    assign error_o = state_q == S_ERR;
`else
    assign wdt_trip = DISABLE;
    assign error_o  = DISABLE;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_i ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = load_done_i ? S_ISSUE : S_LOAD;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = sel_done ? S_NEXT : wdt_trip ? S_ERR : S_WAIT;
            S_NEXT:  state_d = (last_stage && last_round) ? S_STORE : S_ISSUE;
            S_STORE: state_d = store_done_i ? S_DONE : S_STORE;
            S_DONE:  state_d = S_IDLE;
`ifdef ENC_WDT_EN
            default: state_d = start_i ? S_LOAD : S_ERR;
`else
            default: state_d = S_IDLE;
`endif
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end
    assign stage_start_o = (state_q == S_ISSUE) ? NUM_STAGES'(1) << stage_sel_o : '0;
    assign load_o        = state_q == S_LOAD;
    assign store_o       = state_q == S_STORE;
    assign done_o        = state_q == S_DONE;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_ERR);
endmodule

// File: tb/tb_enc_round_sequencer.sv
// tb_enc_round_sequencer: scoreboard bench, 3 stages x 2 rounds, directed scenarios
module tb_enc_round_sequencer;
    logic       clk = 0, rst, start, load_done, store_done;
    logic [2:0] stage_done, stage_start;
    logic [1:0] sel;
    logic [0:0] round;
    logic       load, store, busy, done, error;
    typedef struct { logic [2:0] st; int rnd; } ev_t;
    ev_t        q_ev[$];
    int         q_done[$], q_load[$], q_store[$];
    int         total = 0, bad = 0;
    int         ld_lo = 0, st_lo = 0, dly_round = 0, dly_n = 0;
    logic [2:0] dly_bit = 0, hang_bit = 0;
    always #5 clk = ~clk;
    enc_round_sequencer #(
        .NUM_STAGES(3), .NUM_ROUNDS(2)
`ifdef ENC_WDT_EN
        , .WDT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .load_done_i(load_done), .store_done_i(store_done),
        .stage_done_i(stage_done), .stage_start_o(stage_start), .stage_sel_o(sel), .round_o(round),
        .load_o(load), .store_o(store), .busy_o(busy), .done_o(done), .error_o(error)
    );
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " stage_start"}, int'(stage_start), 0);
        chk({tag, " stage_sel"}, int'(sel), 0);
        chk({tag, " round"}, int'(round), 0);
        chk({tag, " load"}, int'(load), 0);
        chk({tag, " store"}, int'(store), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " error"}, int'(error), 0);
    endtask
    task automatic push_run(input int n, input int dcyc, input int lcyc, input int scyc);
        logic [2:0] seq [6] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
        int         rs  [6] = '{0, 0, 0, 1, 1, 1};
        for (int i = 0; i < n; i++) q_ev.push_back('{seq[i], rs[i]});
        if (dcyc > 0) q_done.push_back(dcyc);
        if (lcyc > 0) q_load.push_back(lcyc);
        if (scyc > 0) q_store.push_back(scyc);
    endtask
    task automatic go();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: no done within %0d cycles", tag, n);
        end
        @(negedge clk);
    endtask
    // monitor: pops the scoreboard whenever the DUT presents a pulse or ends a phase
    initial begin
        int   run_cyc = 0, lc = 0, sc = 0;
        logic pb = 0, pl = 0, ps = 0, pd = 0;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (busy) run_cyc = pb ? run_cyc + 1 : 1;
            if (load) lc = pl ? lc + 1 : 1;
            if (store) sc = ps ? sc + 1 : 1;
            if (stage_start != 0) begin
                if (q_ev.size() == 0) chk("unexpected stage_start", int'(stage_start), 0);
                else begin
                    e = q_ev.pop_front();
                    chk("stage_start order", int'(stage_start), int'(e.st));
                    chk("round at stage_start", int'(round), e.rnd);
                end
            end
            if (done) begin
                if (q_done.size() == 0) chk("unexpected done", int'(done), 0);
                else chk("done cycle", run_cyc, q_done.pop_front());
                chk("busy at done", int'(busy), 1);
            end
            if (pd) chk("busy after done", int'(busy), 0);
            if (pl && !load) begin
                if (q_load.size() == 0) chk("unexpected load", lc, 0);
                else chk("load length", lc, q_load.pop_front());
            end
            if (ps && !store) begin
                if (q_store.size() == 0) chk("unexpected store", sc, 0);
                else chk("store length", sc, q_store.pop_front());
            end
            pb = busy; pl = load; ps = store; pd = done;
        end
    end
    initial begin
        int lcr = 0, scr = 0;
        load_done = 0;
        store_done = 0;
        forever begin
            @(negedge clk);
            if (load) begin lcr++; load_done = lcr > ld_lo; end
            else begin lcr = 0; load_done = 0; end
            if (store) begin scr++; store_done = scr > st_lo; end
            else begin scr = 0; store_done = 0; end
        end
    end
    // stage responder: answers the pulsed stage, optionally late with a wrong-index bit meanwhile
    initial begin
        logic [2:0] s;
        int         d;
        stage_done = 0;
        forever begin
            @(negedge clk);
            if (stage_start != 0 && stage_start != hang_bit) begin
                s = stage_start;
                d = (s == dly_bit && int'(round) == dly_round) ? dly_n : 0;
                repeat (d) begin @(posedge clk); #1 stage_done = {s[1:0], s[2]}; end
                @(posedge clk); #1 stage_done = s;
                @(posedge clk); #1 stage_done = 0;
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        rst = 1;
        start = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 0;
        push_run(6, 21, 1, 1);
        go();
        wait_done("basic");
        dly_bit = 3'd2; dly_round = 0; dly_n = 5;
        push_run(6, 26, 1, 1);
        go();
        wait_done("late stage 1");
        dly_n = 0;
        ld_lo = 4; st_lo = 3;
        push_run(6, 28, 5, 4);
        go();
        wait_done("slow load/store");
        ld_lo = 0; st_lo = 0;
        push_run(6, 21, 1, 1);
        push_run(6, 21, 1, 1);
        @(negedge clk) start = 1;
        wait_done("held start run 1");
        chk("idle between held runs", int'(busy), 0);
        @(negedge clk);
        chk("held start reruns", int'(load), 1);
        start = 0;
        wait_done("held start run 2");
        repeat (2) @(negedge clk);
        chk("single run per start", int'(busy), 0);
        push_run(6, 0, 1, 0);
        go();
        n = 0;
        while (!(round == 1'b1 && sel == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached round 1 stage 2", int'({round, sel}), 6);
        #2 rst = 1;
        #1 chk_zero("abort");
        chk("pending events at abort", q_ev.size(), 0);
        q_ev.delete();
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);
        push_run(6, 21, 1, 1);
        go();
        wait_done("replay after reset");
`ifdef ENC_WDT_EN
        hang_bit = 3'd4;
        push_run(3, 0, 1, 0);
        go();
        n = 0;
        while (stage_start != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!error && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("watchdog latency", n, 8);
        chk("err busy", int'(busy), 0);
        chk("err outputs", int'({stage_start, sel, round, load, store, done}), 0);
        hang_bit = 0;
        push_run(6, 21, 1, 1);
        go();
        chk("error cleared by start", int'(error), 0);
        wait_done("rerun after error");
`else
        chk("error tied low", int'(error), 0);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard drained", q_ev.size() + q_done.size() + q_load.size() + q_store.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
